// File: rtl/mmss_timer.sv
// ----------------------------------------------------------------------------
// mmss_timer -- minutes:seconds stopwatch with start / pause / clear / preset
//
// Counts seconds from a free-running clock using a prescaler of TICK_DIV
// cycles per tick. The count is kept as two binary fields, minutes 0..59 and
// seconds 0..59. In up-count mode the timer stops in DONE when a tick arrives
// at 59:59.
//
// Optional feature (macro MMSS_TIMER_COUNTDOWN_EN):
//   Adds the `mode` input (1 = count down). It is sampled on IDLE->RUN.
//   A down-count stops in DONE when it reaches 00:00. Starting from 00:00 in
//   down mode goes straight to DONE. Without the macro the port and all
//   down-count logic are absent.
//
// Parameters:
//   TICK_DIV    clk cycles per one-second tick (minimum 2)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       start / resume request (level, rising edge acted on)
//   pause       pause request (level, rising edge acted on)
//   clear       clear request (level, rising edge acted on)
//   load        preset load strobe (rising edge acted on, IDLE only)
//   preset_min  preset minutes, clamped to 59 on load
//   preset_sec  preset seconds, clamped to 59 on load
//   mode        1 = count down (only with MMSS_TIMER_COUNTDOWN_EN)
//   minutes     current minutes, registered
//   seconds     current seconds, registered
//   running     high while in RUN
//   done        high while in DONE
// ----------------------------------------------------------------------------
module mmss_timer #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       load,
    input  logic [5:0] preset_min,
    input  logic [5:0] preset_sec,
`ifdef MMSS_TIMER_COUNTDOWN_EN
    input  logic       mode,
`endif
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       done
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;

    logic start_q;
    logic pause_q;
    logic clear_q;
    logic load_q;

    // Low for the first clock after reset release. That first clock only
    // captures the request levels, so a level held high across the release
    // is never mistaken for a fresh edge.
    logic armed;

    logic start_edge;
    logic pause_edge;
    logic clear_edge;
    logic load_edge;

    logic [5:0] load_min;
    logic [5:0] load_sec;

    logic [5:0] inc_min;
    logic [5:0] inc_sec;
    logic       inc_done;

    logic [5:0] step_min;
    logic [5:0] step_sec;
    logic       step_done;

`ifdef MMSS_TIMER_COUNTDOWN_EN
    logic       count_down;
    logic [5:0] dec_min;
    logic [5:0] dec_sec;
    logic       dec_done;
`endif

    assign start_edge = armed & start & ~start_q;
    assign pause_edge = armed & pause & ~pause_q;
    assign clear_edge = armed & clear & ~clear_q;
    assign load_edge  = armed & load  & ~load_q;

    assign load_min = (preset_min > 6'd59) ? 6'd59 : preset_min;
    assign load_sec = (preset_sec > 6'd59) ? 6'd59 : preset_sec;

    // Next value for an up-count tick. At 59:59 the count holds and the
    // timer finishes instead of wrapping.
    always_comb begin
        inc_min  = minutes;
        inc_sec  = seconds + 6'd1;
        inc_done = 1'b0;
        if (seconds >= 6'd59) begin
            if (minutes >= 6'd59) begin
                inc_sec  = seconds;
                inc_done = 1'b1;
            end else begin
                inc_sec = 6'd0;
                inc_min = minutes + 6'd1;
            end
        end
    end

`ifdef MMSS_TIMER_COUNTDOWN_EN
    // Next value for a down-count tick. The tick that lands on 00:00
    // finishes the timer. The 00:00 guard keeps the count from underflowing
    // even though RUN at 00:00 is not reachable in down mode.
    always_comb begin
        dec_min = minutes;
        dec_sec = seconds - 6'd1;
        if (seconds == 6'd0) begin
            dec_sec = 6'd59;
            dec_min = minutes - 6'd1;
        end
        dec_done = (dec_min == 6'd0) && (dec_sec == 6'd0);
        if ((minutes == 6'd0) && (seconds == 6'd0)) begin
            dec_min  = 6'd0;
            dec_sec  = 6'd0;
            dec_done = 1'b1;
        end
    end
`endif

    always_comb begin
        step_min  = inc_min;
        step_sec  = inc_sec;
        step_done = inc_done;
`ifdef MMSS_TIMER_COUNTDOWN_EN
        if (count_down) begin
            step_min  = dec_min;
            step_sec  = dec_sec;
            step_done = dec_done;
        end
`endif
    end

    // Control FSM with registered count and status outputs.
    // Clear wins everywhere. Otherwise each state acts on the
    // highest-priority edge that means something in that state.
    // An edge that a state ignores does not block a lower-priority one.
    // In RUN a pause edge beats a coincident tick, so no count update
    // happens on that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            minutes    <= 6'd0;
            seconds    <= 6'd0;
            running    <= 1'b0;
            done       <= 1'b0;
            start_q    <= 1'b0;
            pause_q    <= 1'b0;
            clear_q    <= 1'b0;
            load_q     <= 1'b0;
            armed      <= 1'b0;
`ifdef MMSS_TIMER_COUNTDOWN_EN
            count_down <= 1'b0;
`endif
        end else begin
            armed   <= 1'b1;
            start_q <= start;
            pause_q <= pause;
            clear_q <= clear;
            load_q  <= load;

            if (clear_edge) begin
                state   <= IDLE;
                presc   <= '0;
                minutes <= 6'd0;
                seconds <= 6'd0;
                running <= 1'b0;
                done    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_edge) begin
                            presc <= '0;
`ifdef MMSS_TIMER_COUNTDOWN_EN
                            count_down <= mode;
                            if (mode && (minutes == 6'd0) && (seconds == 6'd0)) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state   <= RUN;
                                running <= 1'b1;
                            end
`else
                            state   <= RUN;
                            running <= 1'b1;
`endif
                        end else if (load_edge) begin
                            minutes <= load_min;
                            seconds <= load_sec;
                        end
                    end

                    RUN: begin
                        if (pause_edge) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (presc == PRESC_MAX) begin
                            presc   <= '0;
                            minutes <= step_min;
                            seconds <= step_sec;
                            if (step_done) begin
                                state   <= DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end

                    // The prescaler is left alone here so the resume
                    // continues the partial second.
                    PAUSE: begin
                        if (start_edge) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end

                    default: begin
                        state <= DONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmss_timer.sv
// ----------------------------------------------------------------------------
// tb_mmss_timer -- self-checking bench for mmss_timer (TICK_DIV = 4)
//
// The reference model keeps the time as a total number of seconds and the
// sub-second phase as a plain cycle count.
// Directed sequences are followed by a randomized run. Every cycle the
// outputs are compared to the model. Key points are also compared to
// fixed expected values.
// With MMSS_TIMER_COUNTDOWN_EN defined, the mode port is driven and the
// countdown sequences are exercised.
// ----------------------------------------------------------------------------
module tb_mmss_timer;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [5:0] preset_min = 6'd0;
    logic [5:0] preset_sec = 6'd0;
`ifdef MMSS_TIMER_COUNTDOWN_EN
    logic       mode = 1'b0;
`endif
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Reference model state: 0 idle, 1 run, 2 pause, 3 done.
    int mState;
    int mTotal;
    int mPhase;
    bit mDown;
    bit mArmed;
    bit prevStart;
    bit prevPause;
    bit prevClear;
    bit prevLoad;

    mmss_timer #(.TICK_DIV(TICK_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .clear      (clear),
        .load       (load),
        .preset_min (preset_min),
        .preset_sec (preset_sec),
`ifdef MMSS_TIMER_COUNTDOWN_EN
        .mode       (mode),
`endif
        .minutes    (minutes),
        .seconds    (seconds),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int clampPreset(input logic [5:0] v);
        return (int'(v) > 59) ? 59 : int'(v);
    endfunction

    task automatic modelReset();
        mState    = 0;
        mTotal    = 0;
        mPhase    = 0;
        mDown     = 1'b0;
        mArmed    = 1'b0;
        prevStart = 1'b0;
        prevPause = 1'b0;
        prevClear = 1'b0;
        prevLoad  = 1'b0;
    endtask

    // One second of counting, in plain seconds arithmetic.
    task automatic modelTick();
        if (!mDown) begin
            if (mTotal == 59 * 60 + 59) mState = 3;
            else mTotal++;
        end else begin
            mTotal--;
            if (mTotal <= 0) begin
                mTotal = 0;
                mState = 3;
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic modelStep();
        bit se, pe, ce, le;
        if (!rst_n) begin
            modelReset();
            return;
        end
        se = start && !prevStart;
        pe = pause && !prevPause;
        ce = clear && !prevClear;
        le = load  && !prevLoad;
        prevStart = start;
        prevPause = pause;
        prevClear = clear;
        prevLoad  = load;
        if (!mArmed) begin
            mArmed = 1'b1;
            return;
        end
        if (ce) begin
            mState = 0;
            mTotal = 0;
            mPhase = 0;
        end else begin
            case (mState)
                0: begin
                    if (se) begin
                        mPhase = 0;
                        mDown  = 1'b0;
`ifdef MMSS_TIMER_COUNTDOWN_EN
                        mDown = mode;
`endif
                        mState = (mDown && mTotal == 0) ? 3 : 1;
                    end else if (le) begin
                        mTotal = clampPreset(preset_min) * 60 + clampPreset(preset_sec);
                    end
                end
                1: begin
                    if (pe) mState = 2;
                    else if (mPhase == TICK_DIV - 1) begin
                        mPhase = 0;
                        modelTick();
                    end else mPhase++;
                end
                2: if (se) mState = 1;
                default: ;
            endcase
        end
    endtask

    task automatic checkModel();
        checkOutput("minutes", int'(minutes), mTotal / 60);
        checkOutput("seconds", int'(seconds), mTotal % 60);
        checkOutput("running", int'(running), (mState == 1) ? 1 : 0);
        checkOutput("done",    int'(done),    (mState == 3) ? 1 : 0);
    endtask

    // Drive request levels, take one clock edge, update the model, compare.
    task automatic applyStimulus(input bit s, input bit p, input bit c, input bit l);
        start = s;
        pause = p;
        clear = c;
        load  = l;
        @(posedge clk);
        modelStep();
        #1;
        checkModel();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
    endtask

    task automatic checkTime(input string tag, input int mm, input int ss);
        checkOutput({tag, "_min"}, int'(minutes), mm);
        checkOutput({tag, "_sec"}, int'(seconds), ss);
    endtask

    initial begin
        modelReset();
        #2;
        checkTime("reset", 0, 0);
        checkOutput("reset_running", int'(running), 0);
        checkOutput("reset_done", int'(done), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycles(2);

        // Plain start: one second every four cycles after RUN entry.
        applyStimulus(1, 0, 0, 0);
        idleCycles(4);
        checkTime("first_tick", 0, 1);
        idleCycles(4);
        checkTime("second_tick", 0, 2);
        checkOutput("first_running", int'(running), 1);
        applyStimulus(0, 0, 1, 0);
        idleCycles(1);

        // Seconds roll into minutes.
        preset_min = 6'd0;
        preset_sec = 6'd58;
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        idleCycles(4);
        checkTime("roll_a", 0, 59);
        idleCycles(4);
        checkTime("roll_b", 1, 0);
        idleCycles(4);
        checkTime("roll_c", 1, 1);
        applyStimulus(0, 0, 1, 0);
        idleCycles(1);

        // Top of range: finish and hold at 59:59, DONE ignores start/load.
        preset_min = 6'd59;
        preset_sec = 6'd58;
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        idleCycles(4);
        checkTime("top_a", 59, 59);
        idleCycles(4);
        checkTime("top_done", 59, 59);
        checkOutput("top_done_flag", int'(done), 1);
        checkOutput("top_running", int'(running), 0);
        preset_min = 6'd0;
        preset_sec = 6'd0;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1);
        idleCycles(6);
        checkTime("top_hold", 59, 59);
        applyStimulus(0, 0, 1, 0);
        checkTime("top_clear", 0, 0);
        checkOutput("top_clear_done", int'(done), 0);
        idleCycles(1);

        // Pause at prescaler 2, long hold, resume with start held high.
        applyStimulus(1, 0, 0, 0);
        idleCycles(2);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0);
        checkOutput("paused_running", int'(running), 0);
        checkTime("paused", 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkTime("resume_a", 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkTime("resume_b", 0, 1);
        for (int i = 0; i < 47; i++) applyStimulus(1, 0, 0, 0);
        checkTime("resume_held", 0, 12);
        checkOutput("resume_running", int'(running), 1);
        applyStimulus(0, 0, 1, 0);
        idleCycles(1);

        // Clamp, load ignored in RUN, pause coinciding with a tick.
        preset_min = 6'd63;
        preset_sec = 6'd61;
        applyStimulus(0, 0, 0, 1);
        checkTime("clamp", 59, 59);
        preset_min = 6'd0;
        preset_sec = 6'd10;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        preset_min = 6'd5;
        preset_sec = 6'd5;
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkTime("run_load", 0, 10);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkTime("pause_tick", 0, 10);
        checkOutput("pause_tick_running", int'(running), 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkTime("pause_tick_resume", 0, 11);

        // Asynchronous reset mid-run, start held across release.
        idleCycles(3);
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        checkTime("async_rst", 0, 0);
        checkOutput("async_rst_running", int'(running), 0);
        modelReset();
        applyStimulus(1, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0);
        checkOutput("held_start_running", int'(running), 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("restart_running", int'(running), 1);
        applyStimulus(0, 0, 1, 0);
        idleCycles(1);

`ifdef MMSS_TIMER_COUNTDOWN_EN
        // Countdown from 01:01 to 00:00.
        mode = 1'b1;
        preset_min = 6'd1;
        preset_sec = 6'd1;
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        idleCycles(4);
        checkTime("down_a", 1, 0);
        idleCycles(4);
        checkTime("down_b", 0, 59);
        idleCycles(59 * 4);
        checkTime("down_zero", 0, 0);
        checkOutput("down_done", int'(done), 1);
        applyStimulus(0, 0, 1, 0);
        idleCycles(1);
        // Start at 00:00 in down mode finishes at once.
        applyStimulus(1, 0, 0, 0);
        checkOutput("down_zero_start", int'(done), 1);
        applyStimulus(0, 0, 1, 0);
        idleCycles(1);
        // Reset during a countdown.
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        idleCycles(6);
        rst_n = 1'b0;
        #1;
        checkTime("down_rst", 0, 0);
        modelReset();
        idleCycles(1);
        #2;
        rst_n = 1'b1;
        idleCycles(2);
        mode = 1'b0;
`endif

        // Randomized requests against the model.
        for (int i = 0; i < 3000; i++) begin
            preset_min = 6'($urandom_range(0, 63));
            preset_sec = 6'($urandom_range(0, 63));
`ifdef MMSS_TIMER_COUNTDOWN_EN
            mode = 1'($urandom_range(0, 1));
`endif
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 63) == 0,
                          $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmss_timer.md
MMSS_TIMER -- requirements
Module: mmss_timer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100_000_000, giving clk cycles per one-second tick (minimum 2).
REQ-002 The block SHALL have port clk  input  1  100 MHz system clock, rising-edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  start/resume request, level, rising-edge detected internally.
REQ-005 The block SHALL have port pause  input  1  pause request, level, rising-edge detected internally.
REQ-006 The block SHALL have port clear  input  1  clear request, level, rising-edge detected internally.
REQ-007 The block SHALL have port load  input  1  preset load strobe, rising-edge detected internally.
REQ-008 The block SHALL have port preset_min  input  6  preset minutes, binary.
REQ-009 The block SHALL have port preset_sec  input  6  preset seconds, binary.
REQ-010 The block SHALL have port minutes  output  6  current minutes, binary 0..59, registered.
REQ-011 The block SHALL have port seconds  output  6  current seconds, binary 0..59, registered.
REQ-012 The block SHALL have port running  output  1  high while in RUN.
REQ-013 The block SHALL have port done  output  1  high while in DONE.

Function
REQ-014 The block SHALL implement states IDLE, RUN, PAUSE and DONE, with edge priority clear > pause > start > load.
REQ-015 The block SHALL register each request input once and act on (in & ~in_q); a held level SHALL cause exactly one action.
REQ-016 A clear edge in any state SHALL go to IDLE, zero minutes/seconds and the prescaler, and deassert done.
REQ-017 A start edge in IDLE SHALL zero the prescaler and enter RUN.
REQ-018 A start edge in PAUSE SHALL enter RUN with the prescaler resumed, not zeroed.
REQ-019 A pause edge in RUN SHALL enter PAUSE and freeze the prescaler and count.
REQ-020 In RUN, the prescaler SHALL count 0..TICK_DIV-1; the cycle it equals TICK_DIV-1 is a tick, after which it wraps to 0.
REQ-021 The count SHALL update on the clock edge ending the tick cycle, i.e. one update every TICK_DIV cycles.
REQ-022 Up-count: seconds 59 -> 0 SHALL increment minutes.
REQ-023 Up-count: a tick at 59:59 SHALL enter DONE, with the count held at 59:59.
REQ-024 A load edge SHALL be honoured only in IDLE and SHALL copy the preset inputs to minutes/seconds, each clamped to 59 if greater than 59; a load edge in any other state SHALL be ignored.
REQ-025 Up-count SHALL continue from the loaded value.
REQ-026 DONE SHALL hold the count; only clear leaves DONE, and start, pause and load SHALL be ignored there.
REQ-027 Events not listed for a state (pause in IDLE/PAUSE, start in RUN) SHALL be ignored.
REQ-028 A pause edge in the same cycle as a tick SHALL take priority: enter PAUSE with no count update.

Reset
REQ-029 While rst_n is low, the block SHALL be in IDLE with minutes=0, seconds=0, running=0, done=0, prescaler=0 and all edge-detect registers=0, regardless of clk.
REQ-030 Reset asserted mid-RUN SHALL abort immediately; after release the block SHALL stay in IDLE until a start edge.
REQ-031 An input held high across reset release SHALL NOT be seen as an edge.

Configuration
REQ-032 With macro MMSS_TIMER_COUNTDOWN_EN defined, input mode (1 bit, 1 = count down) SHALL exist, sampled only on the IDLE->RUN transition.
REQ-033 With the macro defined and countdown selected: seconds 0 -> 59 SHALL decrement minutes.
REQ-034 With the macro defined and countdown selected: a tick reaching 00:00 SHALL enter DONE, holding 00:00.
REQ-035 With the macro defined, start from IDLE at 00:00 in countdown SHALL go directly to DONE.
REQ-036 Without the macro, the mode port and all down-count logic SHALL be absent, and behaviour SHALL be up-count only.

Verification (TICK_DIV=4)
REQ-037 Reset, start edge -> minutes:seconds = 00:01 four cycles after RUN entry, 00:02 after eight; running=1.
REQ-038 Load 0:58, start, 3 ticks -> 00:59, 01:00, 01:01.
REQ-039 Load 59:58, start -> 59:59, then DONE with done=1, running=0; count stays 59:59; start and load ignored; clear -> 00:00, IDLE.
REQ-040 RUN, pause edge at prescaler=2, hold 20 cycles, start -> next tick after 1 more cycle; start held 50 cycles -> single resume.
REQ-041 Load 63:61 -> 59:59; load in RUN -> ignored; pause coincident with tick -> no increment.
REQ-042 With MMSS_TIMER_COUNTDOWN_EN: load 01:01, mode=1, start -> 01:00, 00:59, ...; reaches 00:00 then done=1; rst_n low mid-count -> outputs 0 asynchronously.
